fft8_frame_ctrl: RTL



---
 rtl/fft8_pkg.sv | 27 ++
 rtl/fft8_lat_tracker.sv | 31 +++
 rtl/fft8_frame_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// Shared types and bus-packing helpers for the 8-point FFT frame controller.
package fft8_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int CPLX_W = 16;

  typedef logic [LOG2N-1:0] idx_t;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic {IN_FILL, IN_WAIT_LAUNCH} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_DRAIN} out_state_t;

  // Element k occupies two adjacent W-bit slots on the 16*W bus: real first, then imag.
  function automatic int re_off(input int k, input int w);
    return 2 * k * w;
  endfunction

  function automatic int im_off(input int k, input int w);
    return (2 * k + 1) * w;
  endfunction

endpackage

// File: rtl/fft8_lat_tracker.sv
// Follows one frame through the fixed-latency FFT: a LAT-deep token shift register plus an in-flight flag.
module fft8_lat_tracker #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  output logic capture,
  output logic inflight
);

  logic [LAT-1:0] r_tok;
  logic           r_inflight;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tok      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_tok <= (r_tok << 1) | LAT'(launch);
      if (launch)
        r_inflight <= 1'b1;
      else if (r_tok[LAT-1])
        r_inflight <= 1'b0;
    end
  end

  assign capture  = r_tok[LAT-1];
  assign inflight = r_inflight;

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Collects 8 serial samples, launches them onto the FFT, captures the result LAT cycles later and drains it serially.
// Build option FFT8_CTRL_SCALE_EN: outputs are scaled by 1/8 with round-half-up.
module fft8_frame_ctrl #(
  parameter int W   = 16,
  parameter int LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic [16*W-1:0]     fft_x,
  input  logic [16*W-1:0]     fft_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic                busy
);

  import fft8_pkg::*;

  function automatic logic signed [W-1:0] scale_out(input logic signed [W-1:0] v);
`ifdef FFT8_CTRL_SCALE_EN
    logic signed [W:0] t;
    t = $signed({v[W-1], v}) + $signed((W+1)'(4));
    t = t >>> 3;
    return t[W-1:0];
`else
    return v;
`endif
  endfunction

  in_state_t  r_in_state, w_in_next;
  out_state_t r_out_state, w_out_next;
  idx_t       r_wr_idx, r_rd_idx;
  logic       w_accept, w_launch, w_capture, w_inflight, w_out_hs;

  logic signed [W-1:0] r_ibuf_re [N];
  logic signed [W-1:0] r_ibuf_im [N];
  logic signed [W-1:0] r_obuf_re [N];
  logic signed [W-1:0] r_obuf_im [N];

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  // A launch needs an empty pipeline and an empty obuf, so a capture never overwrites undrained bins.
  assign w_launch = (r_in_state == IN_WAIT_LAUNCH) && !w_inflight && (r_out_state == OUT_IDLE);

  fft8_lat_tracker #(.LAT(LAT)) u_trk (
    .clk      (clk),
    .reset    (reset),
    .launch   (w_launch),
    .capture  (w_capture),
    .inflight (w_inflight)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state  <= IN_FILL;
      r_out_state <= OUT_IDLE;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
      if (w_launch)
        r_wr_idx <= '0;
      else if (w_accept)
        r_wr_idx <= r_wr_idx + idx_t'(1);
      if (w_out_hs)
        r_rd_idx <= r_rd_idx + idx_t'(1);
    end
  end

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      IN_FILL:        if (w_accept && r_wr_idx == idx_t'(N-1)) w_in_next = IN_WAIT_LAUNCH;
      IN_WAIT_LAUNCH: if (w_launch) w_in_next = IN_FILL;
      default:        w_in_next = IN_FILL;
    endcase
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      OUT_IDLE:  if (w_capture) w_out_next = OUT_DRAIN;
      OUT_DRAIN: if (w_out_hs && r_rd_idx == idx_t'(N-1)) w_out_next = OUT_IDLE;
      default:   w_out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_in_state == IN_FILL);
    out_valid = (r_out_state == OUT_DRAIN);
    out_idx   = out_valid ? r_rd_idx : '0;
    out_last  = out_valid && (r_rd_idx == idx_t'(N-1));
    out_re    = out_valid ? scale_out(r_obuf_re[r_rd_idx]) : '0;
    out_im    = out_valid ? scale_out(r_obuf_im[r_rd_idx]) : '0;
    busy      = (r_in_state == IN_WAIT_LAUNCH) || (r_wr_idx != '0) || w_inflight ||
                (r_out_state == OUT_DRAIN);
  end

  // Sample and result storage; contents are only meaningful under the control state above.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ibuf_re[r_wr_idx] <= in_re;
      r_ibuf_im[r_wr_idx] <= in_im;
    end
    if (w_capture) begin
      for (int k = 0; k < N; k++) begin
        r_obuf_re[k] <= fft_y[re_off(k, W) +: W];
        r_obuf_im[k] <= fft_y[im_off(k, W) +: W];
      end
    end
  end

  always_comb begin
    fft_x = '0;
    for (int k = 0; k < N; k++) begin
      fft_x[re_off(k, W) +: W] = r_ibuf_re[k];
      fft_x[im_off(k, W) +: W] = r_ibuf_im[k];
    end
  end

endmodule
